// File: rtl/tilt_pkg.sv
// Shared types and constants for the tilt-driven ball mover.
// Direction encoding and tilt flag bit positions live here.
package tilt_pkg;

  localparam int POS_W = 10;

  localparam int TILT_LEFT  = 0;
  localparam int TILT_RIGHT = 1;
  localparam int TILT_FWD   = 2;
  localparam int TILT_BACK  = 3;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_NEG  = 2'd1,
    DIR_POS  = 2'd2
  } dir_t;

  typedef enum logic {
    REST   = 1'b0,
    MOVING = 1'b1
  } axis_state_t;

  // Opposing flags together cancel out.
  function automatic dir_t decode_dir(input logic neg,
                                      input logic pos);
    case ({pos, neg})
      2'b01:   return DIR_NEG;
      2'b10:   return DIR_POS;
      default: return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tilt_axis_mover.sv
// One axis: debounce direction over ticks, ramp speed,
// clamp to [0, MAX_POS] and strobe on real position change.
module tilt_axis_mover
  import tilt_pkg::*;
#(
  parameter int MAX_POS      = 639,
  parameter int INIT_POS     = 320,
  parameter int STABLE_TICKS = 3,
  parameter int RAMP_TICKS   = 8,
  parameter int MAX_SPEED    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             enable,
  input  dir_t             dir,
  output logic [POS_W-1:0] pos,
  output logic             inc,
  output logic             dec
);

  localparam int CW = 16;
  localparam logic [CW-1:0] ST_LAST = CW'(STABLE_TICKS - 1);
  localparam logic [CW-1:0] RAMP_N  = CW'(RAMP_TICKS);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [POS_W-1:0] SPD_MAX = POS_W'(MAX_SPEED);
  localparam logic [POS_W-1:0] ONE_S   = POS_W'(1);
  localparam logic [POS_W-1:0] P_MAX   = POS_W'(MAX_POS);
  localparam logic [POS_W-1:0] P_INIT  = POS_W'(INIT_POS);

  axis_state_t       state, state_n;
  dir_t              prev_dir;
  logic [CW-1:0]     stable, stable_n;
  logic [CW-1:0]     ramp, ramp_n;
  logic [POS_W-1:0]  speed, speed_n;
  logic [POS_W-1:0]  pos_n;
  logic              same, move, clamp;
  logic signed [11:0] raw;

  always_comb begin
    same     = (dir == prev_dir);
    stable_n = '0;
    if (same)
      stable_n = (stable == ST_LAST) ? stable
                                     : stable + 1'b1;
    state_n = state;
    speed_n = speed;
    ramp_n  = ramp;
    move    = 1'b0;
    if (!enable) begin
      state_n = REST;
      speed_n = '0;
      ramp_n  = '0;
    end else begin
      unique case (state)
        REST: begin
          if (dir != DIR_NONE && stable_n == ST_LAST) begin
            state_n = MOVING;
            speed_n = ONE_S;
            ramp_n  = ONE_C;
            move    = 1'b1;
          end
        end
        MOVING: begin
          if (!same) begin
            state_n = REST;
            speed_n = '0;
            ramp_n  = '0;
          end else begin
            if (ramp == RAMP_N) begin
              speed_n = (speed >= SPD_MAX) ? SPD_MAX
                                           : speed + 1'b1;
              ramp_n  = ONE_C;
            end else begin
              ramp_n = ramp + 1'b1;
            end
            move = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // 12-bit signed so underflow below zero is visible.
    if (dir == DIR_POS)
      raw = $signed({2'b00, pos}) + $signed({2'b00, speed_n});
    else
      raw = $signed({2'b00, pos}) - $signed({2'b00, speed_n});

    clamp = 1'b0;
    if (raw[11]) begin
      clamp = 1'b1;
      pos_n = '0;
    end else if (raw > $signed({2'b00, P_MAX})) begin
      clamp = 1'b1;
      pos_n = P_MAX;
    end else begin
      pos_n = raw[POS_W-1:0];
    end

    if (!move)
      pos_n = pos;
    if (move && clamp) begin
      speed_n = ONE_S;
      ramp_n  = ONE_C;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= REST;
      prev_dir <= DIR_NONE;
      stable   <= '0;
      ramp     <= '0;
      speed    <= '0;
      pos      <= P_INIT;
      inc      <= 1'b0;
      dec      <= 1'b0;
    end else begin
      inc <= 1'b0;
      dec <= 1'b0;
      if (tick) begin
        state    <= state_n;
        prev_dir <= dir;
        stable   <= stable_n;
        ramp     <= ramp_n;
        speed    <= speed_n;
        pos      <= pos_n;
        inc      <= move && (pos_n > pos);
        dec      <= move && (pos_n < pos);
      end
    end
  end

endmodule

// File: rtl/tilt_ball_mover.sv
// Ball motion from accelerometer tilt flags: tick divider,
// registered tilt, per-axis direction decode and movers.
module tilt_ball_mover
  import tilt_pkg::*;
#(
  parameter int SYSCLK_FREQUENCY_HZ = 100000000,
  parameter int STEP_RATE_HZ        = 60,
  parameter int X_MAX               = 639,
  parameter int Y_MAX               = 479,
  parameter int X_INIT              = 320,
  parameter int Y_INIT              = 240,
  parameter int STABLE_TICKS        = 3,
  parameter int RAMP_TICKS          = 8,
  parameter int MAX_SPEED           = 4
) (
  input  logic             SYSCLK,
  input  logic             reset2,
  input  logic [3:0]       tilt,
  input  logic             enable,
  output logic [POS_W-1:0] ball_x,
  output logic [POS_W-1:0] ball_y,
  output logic             x_inc,
  output logic             x_dec,
  output logic             y_inc,
  output logic             y_dec,
  output logic [3:0]       at_edge,
  output logic             tick
);

  localparam int DIV   = SYSCLK_FREQUENCY_HZ / STEP_RATE_HZ;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [POS_W-1:0] XM = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] YM = POS_W'(Y_MAX);

  logic [3:0]       tilt_q;
  logic [CNT_W-1:0] cnt;
  dir_t             dir_x, dir_y;

  always_ff @(posedge SYSCLK) begin
    if (reset2) begin
      tilt_q <= '0;
      cnt    <= '0;
    end else begin
      tilt_q <= tilt;
      cnt    <= tick ? '0 : cnt + 1'b1;
    end
  end

  assign tick  = (cnt == DIV_LAST);
  assign dir_x = decode_dir(tilt_q[TILT_LEFT],
                            tilt_q[TILT_RIGHT]);
  assign dir_y = decode_dir(tilt_q[TILT_FWD],
                            tilt_q[TILT_BACK]);

  tilt_axis_mover #(
    .MAX_POS      (X_MAX),
    .INIT_POS     (X_INIT),
    .STABLE_TICKS (STABLE_TICKS),
    .RAMP_TICKS   (RAMP_TICKS),
    .MAX_SPEED    (MAX_SPEED)
  ) u_x (
    .clk    (SYSCLK),
    .rst    (reset2),
    .tick   (tick),
    .enable (enable),
    .dir    (dir_x),
    .pos    (ball_x),
    .inc    (x_inc),
    .dec    (x_dec)
  );

  tilt_axis_mover #(
    .MAX_POS      (Y_MAX),
    .INIT_POS     (Y_INIT),
    .STABLE_TICKS (STABLE_TICKS),
    .RAMP_TICKS   (RAMP_TICKS),
    .MAX_SPEED    (MAX_SPEED)
  ) u_y (
    .clk    (SYSCLK),
    .rst    (reset2),
    .tick   (tick),
    .enable (enable),
    .dir    (dir_y),
    .pos    (ball_y),
    .inc    (y_inc),
    .dec    (y_dec)
  );

  assign at_edge = {ball_y == YM, ball_y == '0,
                    ball_x == XM, ball_x == '0};

endmodule

// File: tb/tb_tilt_ball_mover.sv
// Bench for tilt_ball_mover: directed literal checks plus random
// tilt against a per-tick behavioural model compared every cycle.
module tb_tilt_ball_mover;

  localparam int DIV  = 10;
  localparam int ST   = 3;
  localparam int RAMP = 2;
  localparam int MAXS = 3;
  localparam int XMAX = 639;
  localparam int YMAX = 479;

  logic       SYSCLK = 1'b0;
  logic       reset2 = 1'b1;
  logic [3:0] tilt   = 4'd0;
  logic       enable = 1'b1;

  logic [9:0] ball_x, ball_y;
  logic       x_inc, x_dec, y_inc, y_dec, tick;
  logic [3:0] at_edge;

  logic [9:0] e_x, e_y;
  logic       e_xi, e_xd, e_yi, e_yd, e_tick;
  logic [3:0] e_edge;

  int cmp  = 0;
  int mism = 0;
  bit started = 0;

  always #5 SYSCLK = ~SYSCLK;

  tilt_ball_mover #(
    .SYSCLK_FREQUENCY_HZ(100), .STEP_RATE_HZ(10),
    .X_MAX(XMAX), .Y_MAX(YMAX), .X_INIT(320), .Y_INIT(240),
    .STABLE_TICKS(ST), .RAMP_TICKS(RAMP), .MAX_SPEED(MAXS)
  ) dut (
    .SYSCLK(SYSCLK), .reset2(reset2), .tilt(tilt),
    .enable(enable), .ball_x(ball_x), .ball_y(ball_y),
    .x_inc(x_inc), .x_dec(x_dec), .y_inc(y_inc),
    .y_dec(y_dec), .at_edge(at_edge), .tick(tick)
  );

  tilt_ball_mover #(
    .SYSCLK_FREQUENCY_HZ(100), .STEP_RATE_HZ(10),
    .X_MAX(XMAX), .Y_MAX(YMAX), .X_INIT(637), .Y_INIT(240),
    .STABLE_TICKS(ST), .RAMP_TICKS(RAMP), .MAX_SPEED(MAXS)
  ) dut_e (
    .SYSCLK(SYSCLK), .reset2(reset2), .tilt(tilt),
    .enable(enable), .ball_x(e_x), .ball_y(e_y),
    .x_inc(e_xi), .x_dec(e_xd), .y_inc(e_yi),
    .y_dec(e_yd), .at_edge(e_edge), .tick(e_tick)
  );

  // Model: axis 0 = x, 1 = y; dir 0 none, 1 neg, 2 pos.
  int m_pos[2], m_dir[2], m_run[2], m_spd[2], m_ramp[2];
  bit m_mov[2], m_inc[2], m_dec[2];
  int m_cnt;
  logic [3:0] m_tq;

  function automatic int dir_of(bit n, bit p);
    if (n == p) return 0;
    return n ? 1 : 2;
  endfunction

  function automatic int lim(int a);
    return (a == 0) ? XMAX : YMAX;
  endfunction

  task automatic m_reset();
    m_pos[0] = 320; m_pos[1] = 240; m_cnt = 0; m_tq = 4'd0;
    for (int a = 0; a < 2; a++) begin
      m_dir[a] = 0; m_run[a] = 1; m_mov[a] = 0;
      m_spd[a] = 0; m_ramp[a] = 0;
      m_inc[a] = 0; m_dec[a] = 0;
    end
  endtask

  // run = number of consecutive ticks this direction has held
  task automatic m_step(int a, int d, bit en);
    bit same, mv;
    int t;
    same = (d == m_dir[a]);
    if (same) m_run[a]++;
    else begin m_dir[a] = d; m_run[a] = 1; end
    mv = 0;
    if (m_mov[a]) begin
      if (!same || !en) begin
        m_mov[a] = 0; m_spd[a] = 0;
      end else begin
        if (m_ramp[a] == RAMP) begin
          m_spd[a] = (m_spd[a] + 1 > MAXS) ? MAXS : m_spd[a] + 1;
          m_ramp[a] = 1;
        end else m_ramp[a]++;
        mv = 1;
      end
    end else if (en && d != 0 && m_run[a] >= ST) begin
      m_mov[a] = 1; m_spd[a] = 1; m_ramp[a] = 1; mv = 1;
    end
    if (mv) begin
      t = m_pos[a] + ((d == 2) ? m_spd[a] : -m_spd[a]);
      if (t < 0 || t > lim(a)) begin
        t = (t < 0) ? 0 : lim(a);
        m_spd[a] = 1; m_ramp[a] = 1;
      end
      m_inc[a] = t > m_pos[a];
      m_dec[a] = t < m_pos[a];
      m_pos[a] = t;
    end
  endtask

  always @(posedge SYSCLK) begin
    if (reset2) m_reset();
    else begin
      m_inc[0] = 0; m_dec[0] = 0; m_inc[1] = 0; m_dec[1] = 0;
      if (m_cnt == DIV - 1) begin
        m_step(0, dir_of(m_tq[0], m_tq[1]), enable);
        m_step(1, dir_of(m_tq[2], m_tq[3]), enable);
        m_cnt = 0;
      end else m_cnt++;
      m_tq = tilt;
    end
  end

  always @(negedge SYSCLK) begin
    if (started) begin
      logic [3:0] ee;
      ee = {m_pos[1] == YMAX, m_pos[1] == 0,
            m_pos[0] == XMAX, m_pos[0] == 0};
      cmp++;
      if (ball_x !== 10'(m_pos[0]) || ball_y !== 10'(m_pos[1]) ||
          x_inc !== m_inc[0] || x_dec !== m_dec[0] ||
          y_inc !== m_inc[1] || y_dec !== m_dec[1] ||
          at_edge !== ee || tick !== (m_cnt == DIV - 1)) begin
        mism++;
        $display("FAIL model t=%0t got x=%0d y=%0d s=%b%b%b%b e=%b tk=%b need x=%0d y=%0d s=%b%b%b%b e=%b tk=%b",
                 $time, ball_x, ball_y, x_inc, x_dec, y_inc, y_dec,
                 at_edge, tick, m_pos[0], m_pos[1], m_inc[0],
                 m_dec[0], m_inc[1], m_dec[1], ee,
                 m_cnt == DIV - 1);
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    cmp++;
    if (act != exp) begin
      mism++;
      $display("FAIL %s: got %0d need %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset(logic [3:0] t, logic en);
    @(negedge SYSCLK);
    tilt = t; enable = en; reset2 = 1'b1;
    @(negedge SYSCLK);
    reset2 = 1'b0;
  endtask

  // Returns at the negedge of the cycle after the next tick.
  task automatic next_tick(output int n);
    n = 0;
    do begin
      @(negedge SYSCLK);
      n++;
    end while (tick !== 1'b1 && n < 50);
    if (tick !== 1'b1) begin
      cmp++; mism++;
      $display("FAIL tick_timeout: got no tick need tick");
    end
    @(negedge SYSCLK);
  endtask

  initial begin
    int n, px;
    int ex2[9];
    int ex3[5];
    ex2 = '{320, 320, 319, 318, 316, 314, 311, 308, 305};
    ex3 = '{637, 637, 638, 639, 639};

    do_reset(4'b0000, 1'b1);
    started = 1;
    chk("rst_x", ball_x, 320);
    chk("rst_y", ball_y, 240);
    chk("rst_edge", at_edge, 0);
    chk("rst_strobe", {x_inc, x_dec, y_inc, y_dec}, 0);
    for (int i = 0; i < 20; i++) begin
      next_tick(n);
      if (i < 3) chk("tick_period", n, 9);
    end
    chk("idle_x", ball_x, 320);
    chk("idle_y", ball_y, 240);

    do_reset(4'b0001, 1'b1);
    px = 320;
    for (int i = 0; i < 9; i++) begin
      next_tick(n);
      chk("left_x", ball_x, ex2[i]);
      chk("left_xdec", x_dec, int'(ex2[i] != px));
      px = ex2[i];
    end
    chk("left_y", ball_y, 240);

    do_reset(4'b0001, 1'b1);
    for (int i = 0; i < 5; i++) next_tick(n);
    chk("rev_x0", ball_x, 316);
    tilt = 4'b0010;
    next_tick(n);
    chk("rev_x1", ball_x, 316);
    next_tick(n);
    chk("rev_x2", ball_x, 316);
    next_tick(n);
    chk("rev_x3", ball_x, 317);
    chk("rev_xinc", x_inc, 1);

    do_reset(4'b0001, 1'b1);
    for (int i = 0; i < 7; i++) next_tick(n);
    chk("mid_x", ball_x, 311);
    reset2 = 1'b1;
    @(negedge SYSCLK);
    reset2 = 1'b0;
    chk("mid_rst_x", ball_x, 320);
    chk("mid_rst_y", ball_y, 240);
    chk("mid_rst_s", {x_inc, x_dec, y_inc, y_dec}, 0);
    enable = 1'b0; tilt = 4'b0100;
    for (int i = 0; i < 20; i++) next_tick(n);
    chk("dis_y", ball_y, 240);

    do_reset(4'b0010, 1'b1);
    for (int i = 0; i < 5; i++) begin
      next_tick(n);
      chk("edge_x", e_x, ex3[i]);
      chk("edge_xinc", e_xi, int'(i == 2 || i == 3));
    end
    chk("edge_flag", e_edge, 4'b0010);

    do_reset(4'b0011, 1'b1);
    for (int i = 0; i < 10; i++) next_tick(n);
    tilt = 4'b1100;
    for (int i = 0; i < 10; i++) next_tick(n);
    chk("cancel_x", ball_x, 320);
    chk("cancel_y", ball_y, 240);

    do_reset(4'b0000, 1'b1);
    for (int c = 0; c < 8000; c++) begin
      @(negedge SYSCLK);
      if ($urandom_range(0, 119) == 0)
        tilt = 4'($urandom_range(0, 15));
      if (enable && $urandom_range(0, 799) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 39) == 0)
        enable = 1'b1;
      reset2 = ($urandom_range(0, 2499) == 0);
    end
    reset2 = 1'b0;
    @(negedge SYSCLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp, mism);
    $finish;
  end

endmodule

// File: doc/tilt_ball_mover.md
Name: tilt_ball_mover

Overview:
Consumes the 4-bit tilt flags produced by the accelerometer arithmetic stage and turns them into ball motion for the Labyrinth display. It debounces each axis over frame-rate update ticks and ramps ball speed while a tilt is held. It clamps the ball to the playfield and emits the ball position plus one-cycle x/y increment/decrement strobes for the ball/display logic.

Parameters:
SYSCLK_FREQUENCY_HZ, 100000000, system clock frequency.
STEP_RATE_HZ, 60, update tick rate; DIV = SYSCLK_FREQUENCY_HZ/STEP_RATE_HZ (integer, >=2).
X_MAX, 639, rightmost legal x; Y_MAX, 479, bottom legal y.
X_INIT, 320 / Y_INIT, 240, reset position.
STABLE_TICKS, 3, consecutive ticks a direction must persist before motion (>=1).
RAMP_TICKS, 8, moves at the current speed before speed increments (>=1).
MAX_SPEED, 4, max pixels per tick (>=1).

Ports:
SYSCLK  in  1  system clock, all logic on rising edge.
reset2  in  1  synchronous, active-high reset.
tilt  in  4  bit0 left, bit1 right, bit2 forward, bit3 back.
enable  in  1  motion permitted when high.
ball_x  out  10  current x.
ball_y  out  10  current y.
x_inc, x_dec, y_inc, y_dec  out  1 each  one-cycle strobes, position changed in that direction.
at_edge  out  4  bit0 x==0, bit1 x==X_MAX, bit2 y==0, bit3 y==Y_MAX (combinational from position).
tick  out  1  one-cycle update-tick pulse.

Behaviour:
- Reset (reset2 high at an edge): tick counter 0, tilt_q 0, ball_x=X_INIT, ball_y=Y_INIT, all strobes 0, both axes REST, speed 0, stable/ramp counters 0, prev_dir NONE. Applies mid-operation with no residual motion.
- tilt registered into tilt_q every cycle, giving 1 cycle of latency.
- Tick: counter 0..DIV-1; tick=1 in the cycle the counter equals DIV-1, then it wraps to 0. The tick keeps running when enable is low.
- Direction per axis, from tilt_q. X: 01 gives NEG (left), 10 gives POS, and 00 or 11 gives NONE. Y: bit2 only gives NEG (forward/up), bit3 only gives POS, and 00 or 11 gives NONE.
- Stability, evaluated on tick only: if dir==prev_dir, stable_cnt increments, saturating at STABLE_TICKS-1. Otherwise stable_cnt=0 and prev_dir=dir.
- Axis FSM, states REST and MOVING, transitions on tick only:
  - REST to MOVING when dir!=NONE and the post-update stable_cnt==STABLE_TICKS-1. That same tick moves by speed=1 and sets ramp_cnt=1.
  - MOVING to REST when dir!=prev_dir (including NONE) or enable=0. No move on that tick; speed 0.
  - MOVING self-loop: move by speed. If ramp_cnt==RAMP_TICKS, speed=min(speed+1,MAX_SPEED) and ramp_cnt=1 before the move; otherwise ramp_cnt++.
  - enable=0 forces REST with no position change.
- Position arithmetic: compute pos±speed in 12-bit signed, then clamp to [0,X_MAX]/[0,Y_MAX]. There is no wrap-around.
- If a clamp occurs, speed resets to 1 and ramp_cnt to 1 while the axis stays MOVING.
- Position registers update in the cycle after tick. The strobe matching the direction is asserted in that same cycle only if the value actually changed. An axis pinned at the edge gives no strobe.
- Axes are independent; both may strobe in the same cycle.

Decomposition:
- Shared package tilt_pkg holds:
  - dir_t enum {DIR_NONE, DIR_NEG, DIR_POS}
  - axis_state_t {REST, MOVING}
  - tilt bit index constants TILT_LEFT=0, TILT_RIGHT=1, TILT_FWD=2, TILT_BACK=3
  - POS_W=10
- Sub-module tilt_axis_mover (parameters MAX_POS, INIT_POS, STABLE_TICKS, RAMP_TICKS, MAX_SPEED): dir/tick/enable in; pos, inc, dec out. It is instantiated for x and for y.
- The top level holds tilt_q, the tick divider and direction decode.

Test Plan:
(Sim parameters: SYSCLK_FREQUENCY_HZ=100, STEP_RATE_HZ=10 giving DIV=10; STABLE_TICKS=3, RAMP_TICKS=2, MAX_SPEED=3; X_MAX=639, Y_MAX=479.)
1. Reset, tilt=0000, enable=1 -> ball_x=320, ball_y=240, strobes 0, at_edge=0000, tick every 10 cycles, position constant for 20 ticks.
2. tilt=0001 held from reset -> x unchanged for ticks 1-2. After ticks 3..9, x=319,318,316,314,311,308,305 with x_dec on each change; y stays 240.
3. X_INIT=637, tilt=0010 -> x=638 then 639 (x_inc each). The next tick clamps at 639 with no strobe; at_edge[1]=1 and x stays 639.
4. tilt=0011, then 1100, each held 10 ticks -> no position change, no strobes, both axes REST.
5. Reversal: tilt=0001 until x=316 (speed 2), then 0010 -> no move on the next 2 ticks, then x=317 (speed 1) with x_inc.
6. reset2 pulsed 1 cycle mid-motion (x=311) -> next cycle x=320, y=240, no strobe. With enable=0 and tilt=0100 held, y stays 240 indefinitely.
